// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the simplemips instruction-fetch stage
package if_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;
  localparam int PC_STEP    = 4;

  typedef enum logic {
    FETCH = 1'b0,
    KILL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_INST_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - synchronous FIFO with flush, buffering fetched {addr, inst} entries
module if_fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - pipelined IF stage: PC, ROM req/ack, fetch queue, flush; FETCH_PERF_EN adds counters
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INST_W   = DEF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_ack_i,
  input  logic [INST_W-1:0] rom_data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [INST_W-1:0] inst_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_kill_o
`endif
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   kill_addr_q, kill_addr_d;
  logic                run_q;
  logic                push;
  logic                discard;
  logic                fq_full;
  logic                fq_empty;
  logic                req_ack;
  logic [ADDR_W-1:0]   redirect;
  logic [ADDR_W+INST_W-1:0] fq_head;

  assign redirect = redirect_addr_i & ~ADDR_W'(3);

  // run_q keeps the request low during reset and until the first edge after release.
  assign rom_req_o  = run_q && ((state_q == KILL) || !fq_full);
  assign rom_addr_o = (state_q == KILL) ? kill_addr_q : pc_q;
  assign req_ack    = rom_req_o && rom_ack_i;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    push        = 1'b0;
    discard     = 1'b0;
    case (state_q)
      FETCH: begin
        if (flush_i) begin
          pc_d = redirect;
          if (rom_req_o && !rom_ack_i) begin
            state_d     = KILL;
            kill_addr_d = pc_q;
          end else if (req_ack) begin
            discard = 1'b1;
          end
        end else if (req_ack) begin
          push = 1'b1;
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
      end
      KILL: begin
        // The stale request must complete before a new one may issue.
        if (flush_i) pc_d = redirect;
        if (rom_ack_i) begin
          discard = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      run_q       <= 1'b1;
    end
  end

  if_fetch_queue #(
    .W     (ADDR_W + INST_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pc_q, rom_data_i}),
    .pop       (valid_o && ready_i),
    .flush     (flush_i),
    .full      (fq_full),
    .empty     (fq_empty),
    .head      (fq_head)
  );

  assign valid_o           = !fq_empty;
  assign {addr_o, inst_o}  = fq_head;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_kill_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      if (push)    perf_fetch_q <= perf_fetch_q + 32'd1;
      if (discard) perf_kill_q  <= perf_kill_q + 32'd1;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_kill_o  = perf_kill_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a randomized ROM and ID model
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] redirect_addr_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] addr_o;
  logic [31:0] inst_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_kill_o;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_i         (flush_i),
    .redirect_addr_i (redirect_addr_i),
    .rom_req_o       (rom_req_o),
    .rom_addr_o      (rom_addr_o),
    .rom_ack_i       (rom_ack_i),
    .rom_data_i      (rom_data_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .addr_o          (addr_o),
    .inst_o          (inst_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o    (perf_fetch_o),
    .perf_kill_o     (perf_kill_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  fq_entry_t   sb[$];
  logic [31:0] fetch_pc;
  logic [31:0] killed_addr;
  bit          kill_pending;
  bit          mon_en = 1'b0;

  int          lat_min, lat_max, ready_pct, flush_pct;
  bit          spur_en;
  int          ff_mode;
  logic [31:0] ff_addr, ff_redir;
  bit          ff_fired;
  bit          chk_after_ff;
  bit          in_wait;
  int          lat, waited;
  int          m_fetch, m_kill;
  bit          seen_ffc, wrap_ok;
  int          valid_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ID-side monitor: every accepted head must be the oldest expected entry.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      chk("valid_vs_model", valid_o, (sb.size() != 0));
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", addr_o, 64'hDEAD);
        end else begin
          fq_entry_t e;
          e = sb.pop_front();
          chk("head_addr", addr_o, e.addr);
          chk("head_inst", inst_o, e.inst);
        end
      end
    end
  end

  task automatic do_reset();
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    ready_i   = 1'b0;
    rom_ack_i = 1'b0;
    rom_data_i = 32'h0;
    redirect_addr_i = 32'h0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req",   rom_req_o,  0);
      chk("rst_raddr", rom_addr_o, 0);
      chk("rst_valid", valid_o,    0);
      chk("rst_addr",  addr_o,     0);
      chk("rst_inst",  inst_o,     0);
    end
    sb.delete();
    fetch_pc     = 32'h0;
    kill_pending = 1'b0;
    in_wait      = 1'b0;
    m_fetch      = 0;
    m_kill       = 0;
    ff_mode      = 0;
    ff_fired     = 1'b0;
    chk_after_ff = 1'b0;
    valid_cnt    = 0;
    rst_n        = 1'b1;
    mon_en       = 1'b1;
  endtask

  task automatic cycle();
    logic        r_req, r_valid, ack, rdy, fl, exp_req;
    logic [31:0] r_addr, data, redir;
    @(negedge clk);
    r_req   = rom_req_o;
    r_addr  = rom_addr_o;
    r_valid = valid_o;
    if (r_valid) valid_cnt++;
    exp_req = kill_pending || (sb.size() < DEPTH);
    chk("rom_req", r_req, exp_req);
    if (exp_req) chk("rom_addr", r_addr, kill_pending ? killed_addr : fetch_pc);
    if (chk_after_ff) begin
      chk("ff_valid_cleared", r_valid, 0);
      chk("ff_next_req_addr", r_addr, ff_redir & ~32'h3);
      chk_after_ff = 1'b0;
    end
    if (seen_ffc && r_req && r_addr == 32'h0) wrap_ok = 1'b1;

    ack  = 1'b0;
    data = $urandom;
    if (r_req) begin
      if (!in_wait) begin
        in_wait = 1'b1;
        lat     = $urandom_range(lat_min, lat_max);
        waited  = 0;
      end
      if (waited == lat) begin
        ack     = 1'b1;
        data    = r_addr ^ KEY;
        in_wait = 1'b0;
      end else begin
        waited++;
      end
    end else if (spur_en && $urandom_range(0, 9) == 0) begin
      ack = 1'b1;
    end
    rdy   = ($urandom_range(0, 99) < ready_pct);
    fl    = ($urandom_range(0, 99) < flush_pct);
    redir = $urandom;

    if ((ff_mode == 1 && r_req && r_addr == ff_addr && !ack && !kill_pending) ||
        (ff_mode == 2 && r_req && ack && r_valid && !kill_pending) ||
        (ff_mode == 3 && r_req && r_addr == ff_addr && !kill_pending)) begin
      fl           = 1'b1;
      redir        = ff_redir;
      if (ff_mode == 2) begin
        rdy          = 1'b1;
        chk_after_ff = 1'b1;
      end
      ff_mode  = 0;
      ff_fired = 1'b1;
    end

    rom_ack_i       = ack;
    rom_data_i      = data;
    ready_i         = rdy;
    flush_i         = fl;
    redirect_addr_i = redir;

    #2;
    if (fl) begin
      sb.delete();
      if (kill_pending) begin
        if (ack) begin
          kill_pending = 1'b0;
          m_kill++;
        end
      end else if (exp_req && ack) begin
        m_kill++;
      end else if (exp_req) begin
        kill_pending = 1'b1;
        killed_addr  = fetch_pc;
      end
      fetch_pc = redir & ~32'h3;
    end else if (kill_pending) begin
      if (ack) begin
        kill_pending = 1'b0;
        m_kill++;
      end
    end else if (exp_req && ack) begin
      sb.push_back('{addr: fetch_pc, inst: fetch_pc ^ KEY});
      if (fetch_pc == 32'hFFFFFFFC) seen_ffc = 1'b1;
      fetch_pc = fetch_pc + 32'd4;
      m_fetch++;
    end
  endtask

  task automatic set_mode(input int lmin, input int lmax, input int rp, input int fp, input bit sp);
    lat_min   = lmin;
    lat_max   = lmax;
    ready_pct = rp;
    flush_pct = fp;
    spur_en   = sp;
  endtask

  initial begin
    seen_ffc = 1'b0;
    wrap_ok  = 1'b0;
    set_mode(0, 0, 0, 0, 1'b0);

    // zero-wait stream
    do_reset();
    set_mode(0, 0, 100, 0, 1'b0);
    repeat (30) cycle();
    chk("zero_wait_valid_cycles", valid_cnt, 29);

    // wait states with backpressure, then drain
    do_reset();
    set_mode(3, 3, 0, 0, 1'b0);
    repeat (20) cycle();
    @(negedge clk);
    chk("full_req_low", rom_req_o, 0);
    chk("full_valid",   valid_o,   1);
    chk("full_head",    addr_o,    32'h0);
    chk("full_inst",    inst_o,    KEY);
    set_mode(3, 3, 100, 0, 1'b0);
    repeat (20) cycle();

    // flush while waiting on 0x8
    do_reset();
    set_mode(3, 3, 100, 0, 1'b0);
    ff_mode  = 1;
    ff_addr  = 32'h8;
    ff_redir = 32'h103;
    repeat (30) cycle();
    chk("ff_wait_fired", ff_fired, 1);

    // flush with simultaneous ack and pop
    do_reset();
    set_mode(0, 0, 100, 0, 1'b0);
    ff_mode  = 2;
    ff_redir = 32'h42;
    repeat (12) cycle();
    chk("ff_ackpop_fired", ff_fired, 1);

    // PC wrap via redirect near the top of the address space
    do_reset();
    set_mode(0, 0, 100, 0, 1'b0);
    ff_mode  = 3;
    ff_addr  = 32'h10;
    ff_redir = 32'hFFFFFFF9;
    repeat (15) cycle();
    chk("wrap_seen", wrap_ok, 1);

    // randomized traffic with flushes, stalls and stray acks
    do_reset();
    set_mode(0, 3, 70, 6, 1'b1);
    repeat (1500) cycle();
`ifdef FETCH_PERF_EN
    @(negedge clk);
    chk("perf_fetch", perf_fetch_o, m_fetch);
    chk("perf_kill",  perf_kill_o,  m_kill);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
